// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus between result producers.
// Each producer owns a one-entry holding buffer; one buffered result is broadcast per cycle.
module cdb_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SRC_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]          cdb_src,
    output logic                      busy
);

    logic [N_REQ-1:0]  buf_valid_q;
    logic [TAG_W-1:0]  buf_tag_q  [N_REQ];
    logic [DATA_W-1:0] buf_data_q [N_REQ];
    logic [SRC_W-1:0]  rr_ptr_q;

    logic [N_REQ-1:0]  grant;
    logic [N_REQ-1:0]  accept;
    logic [SRC_W-1:0]  win;
    logic [SRC_W-1:0]  rr_next;
    logic              any_grant;

    // Two passes: indices at or above the pointer first, then the wrapped-around ones.
    always_comb begin
        grant     = '0;
        win       = '0;
        any_grant = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!any_grant && buf_valid_q[i] && (i >= 32'(rr_ptr_q))) begin
                any_grant = 1'b1;
                grant[i]  = 1'b1;
                win       = SRC_W'(i);
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!any_grant && buf_valid_q[i] && (i < 32'(rr_ptr_q))) begin
                any_grant = 1'b1;
                grant[i]  = 1'b1;
                win       = SRC_W'(i);
            end
        end
    end

    always_comb begin
        rr_next = '0;
        if (win != SRC_W'(N_REQ - 1)) begin
            rr_next = win + 1'b1;
        end
    end

    // A granted buffer frees up this cycle, so it can take a new result at the same edge.
    assign req_ready = ~buf_valid_q | grant;
    assign accept    = req_valid & req_ready & {N_REQ{~flush}};
    assign busy      = |buf_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= '0;
            rr_ptr_q    <= '0;
            cdb_valid   <= 1'b0;
            cdb_tag     <= '0;
            cdb_data    <= '0;
            cdb_src     <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                buf_tag_q[i]  <= '0;
                buf_data_q[i] <= '0;
            end
        end else begin
            buf_valid_q <= flush ? '0 : (accept | (buf_valid_q & ~grant));
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (accept[i]) begin
                    buf_tag_q[i]  <= req_tag[i*TAG_W +: TAG_W];
                    buf_data_q[i] <= req_data[i*DATA_W +: DATA_W];
                end
            end
            cdb_valid <= any_grant & ~flush;
            if (any_grant) begin
                cdb_tag  <= buf_tag_q[win];
                cdb_data <= buf_data_q[win];
                cdb_src  <= win;
            end
            // The pointer survives a flush so fairness carries across it.
            if (any_grant && !flush) begin
                rr_ptr_q <= rr_next;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a reference model fills a scoreboard of expected
// broadcasts, a negedge monitor pops and compares, and scenario tasks add directed checks.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [19:0] req_tag = '0;
    logic [127:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [1:0]  cdb_src;
    logic        busy;

    int checks = 0;
    int passes = 0;

    cdb_arbiter #(.N_REQ(4), .TAG_W(5), .DATA_W(32), .SRC_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [3:0]  m_valid = '0;
    logic [4:0]  m_tag [4];
    logic [31:0] m_data [4];
    int          m_ptr = 0;
    logic        exp_valid = 1'b0;
    logic [38:0] exp_q [$];
    logic        mon_en = 1'b0;
    int          g;
    logic [3:0]  rdy;

    function automatic int find_grant(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready(input logic [3:0] v, input int p);
        logic [3:0] r;
        int w;
        r = ~v;
        w = find_grant(v, p);
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid   = '0;
            m_ptr     = 0;
            exp_valid = 1'b0;
        end else begin
            g   = find_grant(m_valid, m_ptr);
            rdy = model_ready(m_valid, m_ptr);
            exp_valid = (g >= 0) && !flush;
            if (exp_valid) exp_q.push_back({m_tag[g], m_data[g], 2'(g)});
            if (flush) begin
                m_valid = '0;
            end else begin
                if (g >= 0) begin
                    m_valid[g] = 1'b0;
                    m_ptr = (g + 1) % 4;
                end
                for (int i = 0; i < 4; i++) begin
                    if (req_valid[i] && rdy[i]) begin
                        m_valid[i] = 1'b1;
                        m_tag[i]   = req_tag[i*5 +: 5];
                        m_data[i]  = req_data[i*32 +: 32];
                    end
                end
            end
        end
    end

    // Scoreboard monitor
    logic [38:0] want;
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (cdb_valid !== exp_valid)
                $display("FAIL sb_valid: got %b want %b at %0t", cdb_valid, exp_valid, $time);
            else passes++;
            if (cdb_valid === 1'b1 && exp_valid && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checks++;
                if ({cdb_tag, cdb_data, cdb_src} !== want)
                    $display("FAIL sb_data: got tag %0d data %h src %0d want tag %0d data %h src %0d",
                             cdb_tag, cdb_data, cdb_src, want[38:34], want[33:2], want[1:0]);
                else passes++;
            end
            checks++;
            if (req_ready !== model_ready(m_valid, m_ptr) || busy !== (|m_valid))
                $display("FAIL sb_ready_busy: got rdy %b busy %b want rdy %b busy %b",
                         req_ready, busy, model_ready(m_valid, m_ptr), |m_valid);
            else passes++;
        end
    end

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            mon_en = 1'b1;
            checks++;
            if (cdb_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b1111)
                $display("FAIL reset_outputs: got v %b busy %b rdy %b want 0 0 1111",
                         cdb_valid, busy, req_ready);
            else passes++;
        end
        rst = 1'b0; req_valid = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_no_load: got busy %b want 0", busy);
        else passes++;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001; req_tag[4:0] = 5'd3; req_data[31:0] = 32'hDEADBEEF;
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (cdb_valid !== 1'b0) $display("FAIL single_early: got %b want 0", cdb_valid);
        else passes++;
        @(negedge clk);
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {1'b1, 5'd3, 32'hDEADBEEF, 2'd0})
            $display("FAIL single_bcast: got v %b tag %0d data %h src %0d want 1 3 deadbeef 0",
                     cdb_valid, cdb_tag, cdb_data, cdb_src);
        else passes++;
        @(negedge clk);
        checks++;
        if (cdb_valid !== 1'b0) $display("FAIL single_once: got %b want 0", cdb_valid);
        else passes++;
    endtask

    task automatic test_collision();
        do_reset();
        req_valid = 4'b0011;
        req_tag[4:0] = 5'd1; req_data[31:0]  = 32'd11;
        req_tag[9:5] = 5'd2; req_data[63:32] = 32'd22;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {1'b1, 5'd1, 32'd11, 2'd0})
            $display("FAIL collide_first: got v %b tag %0d data %0d src %0d want 1 1 11 0",
                     cdb_valid, cdb_tag, cdb_data, cdb_src);
        else passes++;
        @(negedge clk);
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {1'b1, 5'd2, 32'd22, 2'd1})
            $display("FAIL collide_second: got v %b tag %0d data %0d src %0d want 1 2 22 1",
                     cdb_valid, cdb_tag, cdb_data, cdb_src);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int seq [4];
        logic [3:0] mr;
        int exp_src;
        int nb;
        do_reset();
        // One grant to unit 0 leaves the pointer at 1
        req_valid = 4'b0001; req_tag[4:0] = 5'd30; req_data[31:0] = 32'h55;
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0;
            req_tag[i*5 +: 5]   = 5'(i * 8);
            req_data[i*32 +: 32] = 32'(i * 1000);
        end
        req_valid = 4'b1111;
        exp_src = 1;
        nb = 0;
        for (int c = 0; c < 12; c++) begin
            mr = model_ready(m_valid, m_ptr);
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (mr[i]) begin
                    seq[i]++;
                    req_tag[i*5 +: 5]   = 5'(i * 8 + (seq[i] % 8));
                    req_data[i*32 +: 32] = 32'(i * 1000 + seq[i]);
                end
            end
            if (c >= 1) begin
                nb++;
                checks++;
                if (cdb_valid !== 1'b1 || cdb_src !== 2'(exp_src))
                    $display("FAIL rr_src: cycle %0d got v %b src %0d want 1 %0d",
                             c, cdb_valid, cdb_src, exp_src);
                else passes++;
                exp_src = (exp_src + 1) % 4;
                checks++;
                if ($countones(req_ready) != 1)
                    $display("FAIL rr_ready_onehot: cycle %0d got %b want one-hot", c, req_ready);
                else passes++;
            end
        end
        req_valid = '0;
        repeat (5) @(negedge clk);
        checks++;
        if (nb != 11 || busy !== 1'b0)
            $display("FAIL rr_drain: got bcasts %0d busy %b want 11 0", nb, busy);
        else passes++;
    endtask

    task automatic test_backpressure();
        logic [4:0] exp_tag [6];
        logic       exp_rdy2 [6];
        exp_tag  = '{5'd0, 5'd10, 5'd11, 5'd12, 5'd22, 5'd0};
        exp_rdy2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        req_valid = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            req_tag[i*5 +: 5]   = 5'(10 + i);
            req_data[i*32 +: 32] = 32'(100 + i);
        end
        @(negedge clk);
        req_valid = 4'b0100; req_tag[14:10] = 5'd22; req_data[95:64] = 32'd222;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 3) req_valid = '0;
            checks++;
            if (req_ready[2] !== exp_rdy2[c])
                $display("FAIL bp_ready2: step %0d got %b want %b", c, req_ready[2], exp_rdy2[c]);
            else passes++;
            if (c >= 1 && c <= 4) begin
                checks++;
                if (cdb_valid !== 1'b1 || cdb_tag !== exp_tag[c])
                    $display("FAIL bp_tag: step %0d got v %b tag %0d want 1 %0d",
                             c, cdb_valid, cdb_tag, exp_tag[c]);
                else passes++;
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        req_valid = 4'b1110;
        for (int i = 1; i < 4; i++) begin
            req_tag[i*5 +: 5]   = 5'(4 + i);
            req_data[i*32 +: 32] = 32'(40 + i);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 5'd5)
            $display("FAIL flush_pre: got v %b tag %0d want 1 5", cdb_valid, cdb_tag);
        else passes++;
        flush = 1'b1;
        req_valid = 4'b0001; req_tag[4:0] = 5'd9; req_data[31:0] = 32'd99;
        checks++;
        if (req_ready !== 4'b0111)
            $display("FAIL flush_ready: got %b want 0111", req_ready);
        else passes++;
        @(negedge clk);
        flush = 1'b0; req_valid = '0;
        checks++;
        if (cdb_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b1111)
            $display("FAIL flush_clear: got v %b busy %b rdy %b want 0 0 1111",
                     cdb_valid, busy, req_ready);
        else passes++;
        // Pointer must still be 2: unit 2 wins over unit 1
        req_valid = 4'b0110;
        req_tag[9:5] = 5'd13; req_tag[14:10] = 5'd14;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd2 || cdb_tag !== 5'd14)
            $display("FAIL flush_ptr_first: got v %b src %0d tag %0d want 1 2 14",
                     cdb_valid, cdb_src, cdb_tag);
        else passes++;
        @(negedge clk);
        checks++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd1 || cdb_tag !== 5'd13)
            $display("FAIL flush_ptr_second: got v %b src %0d tag %0d want 1 1 13",
                     cdb_valid, cdb_src, cdb_tag);
        else passes++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_collision();
        test_round_robin();
        test_backpressure();
        test_flush();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
        else passes++;
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus between the out-of-order core's result producers (ALU, load/store queue, future multiply/divide and branch units). Each producer hands its completed result over with a valid/ready handshake into a private one-entry holding buffer. The arbiter broadcasts one buffered result per cycle on a registered CDB consumed by the reservation stations, LSQ and reorder buffer. No result is dropped when two units finish in the same cycle.

## Interface
- N_REQ, 4: number of requesting functional units; index 0 = ALU, 1 = LSQ, 2 and 3 are spare.
- TAG_W, 5: ROB tag width.
- DATA_W, 32: result data width.
- SRC_W, 2: width of the source index; must satisfy 2^SRC_W >= N_REQ.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush (mispredict/exception): discards all buffered results.
- req_valid  in  N_REQ  producer i has a result.
- req_tag  in  N_REQ*TAG_W  producer i tag at [i*TAG_W +: TAG_W].
- req_data  in  N_REQ*DATA_W  producer i data at [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  buffer i can accept this cycle.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_W  broadcast ROB tag.
- cdb_data  out  DATA_W  broadcast result.
- cdb_src  out  SRC_W  index of the producer being broadcast.
- busy  out  1  at least one holding buffer is occupied.

## Operation
- Per-requester state: buf_valid[i], buf_tag[i], buf_data[i]. Global state: rr_ptr (SRC_W bits).
- Grant (combinational): the first i with buf_valid[i], searching from rr_ptr upward and wrapping modulo N_REQ. grant is one-hot or zero. When no buffer is valid, grant = 0.
- req_ready[i] = ~buf_valid[i] | grant[i]. This is a full-throughput pass-through: a granted buffer accepts a new result in the same cycle. req_ready never depends on req_valid.
- Accept: on each edge with req_valid[i] & req_ready[i] & ~flush, load buf_*[i] and set buf_valid[i]=1.
- Drain: on each edge with grant[i] and no accept into buffer i, clear buf_valid[i].
- CDB registers, updated every edge:
  - cdb_valid <= |grant & ~flush.
  - On a grant, cdb_tag/cdb_data/cdb_src load from the winning buffer. Otherwise they hold their previous values.
- Pointer: on a grant to buffer w, rr_ptr <= (w+1) mod N_REQ. With no grant, rr_ptr holds.
- Flush:
  - Clears all buf_valid and forces cdb_valid=0 at that edge.
  - Accepts in the flush cycle are discarded.
  - rr_ptr is unchanged.
  - req_ready is still computed normally during flush.
- busy = |buf_valid (combinational).
- Producers must hold req_valid/tag/data stable until they see req_ready high.

## Timing
- Reset (rst=1 at an edge): buf_valid=0, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0. After reset, req_ready is all ones and busy=0. rst has priority over flush.
- Latency: a result accepted at edge E is in its buffer after E. If uncontended, it is granted in the following cycle and appears on the CDB after edge E+1, i.e. 2 edges from request to broadcast.
- Throughput: one broadcast per cycle whenever any buffer is occupied. A producer holding req_valid continuously without contention broadcasts every cycle.
- Fairness: a pending buffer is granted within N_REQ cycles of becoming valid.
- Simultaneous completion: all N_REQ units asserting req_valid at the same edge are all accepted. They broadcast on N_REQ consecutive cycles in round-robin order from rr_ptr.
- Backpressure: an occupied, ungranted buffer drives req_ready[i]=0. The producer stalls and its result is not lost.
- Pointer wrap: after a grant to N_REQ-1, rr_ptr = 0.

## Test plan
- Reset: assert rst for 2 cycles with req_valid=4'b1111 -> cdb_valid=0, busy=0, req_ready=4'b1111 throughout; no buffer is loaded.
- Single ALU result: req_valid[0]=1 for one cycle, tag=5'd3, data=32'hDEADBEEF -> two edges later cdb_valid=1, cdb_tag=3, cdb_data=DEADBEEF, cdb_src=0 for exactly one cycle.
- ALU/LSQ collision: units 0 (tag 1, data 11) and 1 (tag 2, data 22) assert in the same cycle with rr_ptr=0 -> CDB shows (1,11,src 0), then (2,22,src 1) on consecutive cycles; neither result is dropped.
- Round-robin fairness: all four units hold req_valid with distinct tags for 12 cycles, rr_ptr=1 at start -> cdb_src sequence 1,2,3,0,1,2,3,0,...; each unit gets req_ready once per 4 cycles.
- Backpressure stability: unit 2 holds req_valid while buffer 2 is occupied and ungranted -> req_ready[2]=0 and the buffered tag/data are unchanged until the grant.
- Flush mid-operation: three buffers occupied, flush=1 for one cycle -> cdb_valid=0 on the next cycle, busy=0, rr_ptr unchanged, and no flushed tag ever appears on the CDB.
